// File: rtl/leitor_ps2_sinc_if.sv
// Receiver result bundle: decoded code with prefix flags, result/error strobes and busy.
// The release-prefix flag is named key_release because `release` is a reserved word.
interface leitor_ps2_sinc_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] code;
    logic                 code_valid;
    logic                 extended;
    logic                 key_release;
    logic                 parity_err;
    logic                 frame_err;
    logic                 timeout_err;
    logic                 busy;

    modport master (
        output code, code_valid, extended, key_release,
        output parity_err, frame_err, timeout_err, busy
    );

    modport slave (
        input code, code_valid, extended, key_release,
        input parity_err, frame_err, timeout_err, busy
    );
endinterface

// File: rtl/leitor_ps2_sinc.sv
// clk-synchronous PS/2 device-to-host receiver: synchronise, de-glitch, frame check,
// watchdog abort and optional E0/F0 prefix folding; results leave as one-cycle strobes.
module leitor_ps2_sinc #(
    parameter int DATA_BITS     = 8,
    parameter int FILTER_LEN    = 4,
    parameter int TIMEOUT       = 50000,
    parameter int DECODE_PREFIX = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    leitor_ps2_sinc_if.master rx
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam bit PREFIX_EN = (DECODE_PREFIX != 0) && (DATA_BITS == 8);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]           clk_s, dat_s;
    logic                 filt, filt_q;
    logic [FLT_W-1:0]     flt_cnt;
    logic                 fall, data_bit;

    state_t               state_q, state_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [DATA_BITS-1:0] sh_q, sh_nxt;
    logic                 par_ok_q, par_ok_nxt;
    logic [WD_W-1:0]      wd_q, wd_nxt;
    logic                 ext_pend_q, ext_pend_nxt, rel_pend_q, rel_pend_nxt;
    logic [DATA_BITS-1:0] code_q, code_nxt;
    logic                 ext_q, ext_nxt, rel_q, rel_nxt;
    logic                 valid_q, valid_nxt, perr_q, perr_nxt;
    logic                 ferr_q, ferr_nxt, terr_q, terr_nxt;
    logic                 expired;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s   <= 2'b11;
            dat_s   <= 2'b11;
            filt    <= 1'b1;
            filt_q  <= 1'b1;
            flt_cnt <= '0;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk};
            dat_s  <= {dat_s[0], ps2_data};
            filt_q <= filt;
            // The filtered level only moves after FILTER_LEN consecutive disagreeing samples
            if (clk_s[1] == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                filt    <= clk_s[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    assign fall     = ~filt & filt_q;
    assign data_bit = dat_s[1];
    assign expired  = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            sh_q       <= '0;
            par_ok_q   <= 1'b0;
            wd_q       <= '0;
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            idx_q      <= idx_nxt;
            sh_q       <= sh_nxt;
            par_ok_q   <= par_ok_nxt;
            wd_q       <= wd_nxt;
            ext_pend_q <= ext_pend_nxt;
            rel_pend_q <= rel_pend_nxt;
            code_q     <= code_nxt;
            ext_q      <= ext_nxt;
            rel_q      <= rel_nxt;
            valid_q    <= valid_nxt;
            perr_q     <= perr_nxt;
            ferr_q     <= ferr_nxt;
            terr_q     <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        sh_nxt       = sh_q;
        par_ok_nxt   = par_ok_q;
        wd_nxt       = wd_q;
        ext_pend_nxt = ext_pend_q;
        rel_pend_nxt = rel_pend_q;
        code_nxt     = code_q;
        ext_nxt      = ext_q;
        rel_nxt      = rel_q;
        valid_nxt    = 1'b0;
        perr_nxt     = 1'b0;
        ferr_nxt     = 1'b0;
        terr_nxt     = 1'b0;

        if (state_q == IDLE || fall) wd_nxt = '0;
        else                         wd_nxt = wd_q + WD_W'(1);

        // Watchdog expiry outranks an edge landing in the same cycle
        if (expired) begin
            terr_nxt     = 1'b1;
            state_nxt    = IDLE;
            ext_pend_nxt = 1'b0;
            rel_pend_nxt = 1'b0;
            wd_nxt       = '0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_bit) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end
                end
                DATA: begin
                    sh_nxt = {data_bit, sh_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_W'(DATA_BITS - 1)) state_nxt = PARITY;
                    else                                idx_nxt   = idx_q + IDX_W'(1);
                end
                PARITY: begin
                    par_ok_nxt = (^sh_q) ^ data_bit;
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (!data_bit || !par_ok_q) begin
                        ferr_nxt     = ~data_bit;
                        perr_nxt     = data_bit;
                        ext_pend_nxt = 1'b0;
                        rel_pend_nxt = 1'b0;
                    end else if (PREFIX_EN && sh_q == DATA_BITS'(8'hE0)) begin
                        ext_pend_nxt = 1'b1;
                    end else if (PREFIX_EN && sh_q == DATA_BITS'(8'hF0)) begin
                        rel_pend_nxt = 1'b1;
                    end else begin
                        valid_nxt    = 1'b1;
                        code_nxt     = sh_q;
                        ext_nxt      = ext_pend_q;
                        rel_nxt      = rel_pend_q;
                        ext_pend_nxt = 1'b0;
                        rel_pend_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rx.code        = code_q;
    assign rx.code_valid  = valid_q;
    assign rx.extended    = ext_q;
    assign rx.key_release = rel_q;
    assign rx.parity_err  = perr_q;
    assign rx.frame_err   = ferr_q;
    assign rx.timeout_err = terr_q;
    assign rx.busy        = (state_q != IDLE);
endmodule

// File: doc/leitor_ps2_sinc.md
# leitor_ps2_sinc

Parametrised, system-clock-synchronous PS/2 device-to-host receiver. It synchronises and de-glitches the raw PS/2 clock and data lines and checks start, odd-parity and stop framing. It recovers from stalled frames with a watchdog, and can fold the E0 (extended) and F0 (release) prefixes into flags on the following code. It sits between the PS/2 pins and the keyboard decode logic, and replaces the PS/2-clock-driven reader: all logic runs on `clk`, and a frame is reported with a single-cycle strobe.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first, range 5..9.
- `FILTER_LEN`, default 4: consecutive `clk` samples the synchronised PS/2 clock must hold a new level before the filtered clock changes, range 2..255.
- `TIMEOUT`, default 50000: `clk` cycles allowed between filtered falling edges inside a frame before abort. Counter width is $clog2(TIMEOUT+1).
- `DECODE_PREFIX`, default 1: 1 enables E0/F0 folding. Legal only with DATA_BITS=8; otherwise the block behaves as 0.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `code` output DATA_BITS: last emitted code; held until the next `code_valid`.
- `code_valid` output 1: one-cycle strobe; `code`, `extended` and `release` are valid in this cycle.
- `extended` output 1: E0 preceded `code`; held with `code`.
- `release` output 1: F0 preceded `code`; held with `code`.
- `parity_err` output 1: one-cycle strobe on an odd-parity failure.
- `frame_err` output 1: one-cycle strobe when the stop bit is 0.
- `timeout_err` output 1: one-cycle strobe when the watchdog aborts a frame.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Synchronisers: two flip-flops on each pin, reset to 1.
- Filter: the filtered clock resets to 1. A counter counts consecutive synchronised samples that differ from the filtered level. When the count reaches FILTER_LEN, the filtered level flips and the counter clears. Any sample equal to the filtered level clears the counter.
- Falling-edge detect: a registered copy of the filtered clock; `fall` is true when the filtered clock is 0 and the registered copy is 1. Synchronised data is sampled in the same cycle.
- FSM states IDLE, DATA, PARITY, STOP, all acting only on `fall`:
  - IDLE: data 0 → DATA, bit index 0. Data 1 → stay in IDLE, no error.
  - DATA: shift the bit into the MSB of a right-shifting register. After DATA_BITS bits → PARITY.
  - PARITY: store `par_ok` = XOR of the data bits and the parity bit, which must equal 1. Go to STOP.
  - STOP:
    - Data 0 → `frame_err`. Frame error takes precedence over parity error.
    - Else if not `par_ok` → `parity_err`.
    - Else the byte is good.
    - Always return to IDLE.
- Prefix folding with DECODE_PREFIX=1, on a good byte:
  - E0 sets `ext_pend`; no strobe.
  - F0 sets `rel_pend`; no strobe.
  - Any other byte pulses `code_valid` with `extended`=`ext_pend` and `release`=`rel_pend`, then clears both.
  - Any error strobe clears both pending flags.
- With DECODE_PREFIX=0: every good byte strobes `code_valid`; `extended` and `release` stay 0.
- Watchdog:
  - Clears on every `fall` and while in IDLE.
  - In any other state, when it reaches TIMEOUT it pulses `timeout_err`, discards the partial frame, clears the pending flags and returns to IDLE.
  - An edge arriving in the same cycle the watchdog expires is ignored; the abort wins.
- Strobes are mutually exclusive; at most one of the four fires per cycle.

## Timing
- Reset values: `code`=0, `code_valid`=0, `extended`=0, `release`=0, all error strobes 0, `busy`=0. Internally: state IDLE, filtered clock 1, synchronisers 1, counters 0, pending flags 0.
- Reset asserted mid-frame discards the frame; no strobe is produced on or after release of reset.
- Latency: let edge 0 be the first `clk` edge sampling `ps2_clk` low at the stop bit. The result strobe is high in the cycle after edge FILTER_LEN+2, and lasts exactly one cycle.
- `busy` rises in the cycle after the start-bit `fall` and falls together with the result strobe.
- Filter constraint: FILTER_LEN clock periods must be well under the 5 µs PS/2 data hold time, so the sampled data belongs to the correct bit.
- Glitch rule: pulses shorter than FILTER_LEN cycles on `ps2_clk` never produce `fall`.

## Test plan
All scenarios use `clk` at 50 MHz and `ps2_clk` at 12.5 kHz with defaults, unless noted.
- Frame 0x1C, parity 0, stop 1 → one `code_valid`, `code`=0x1C, `extended`=0, `release`=0, no error strobe, latency FILTER_LEN+2 as specified.
- Frames E0 (parity 0), F0 (parity 1), 0x75 (parity 0) → exactly one `code_valid`, with `code`=0x75, `extended`=1, `release`=1. A following 0x1C frame → `extended`=0, `release`=0.
- Frame 0x1C with parity 1 → one `parity_err` pulse, no `code_valid`, `code` unchanged. Frame 0x1C with stop bit 0 and bad parity → `frame_err` only.
- TIMEOUT=1000: start bit plus 4 data bits, then clocking stops → `timeout_err` exactly 1000 cycles after the last `fall`, `busy` drops. The next good 0x29 frame decodes correctly.
- FILTER_LEN=4: 1- to 3-cycle low glitches injected on `ps2_clk` while idle and mid-frame → no extra bits, frame 0x5A decodes correctly.
- `reset` asserted low for 3 cycles after the 5th data bit of an F0 frame → all outputs 0, no strobes. The next 0x1C frame gives `release`=0.
